// File: rtl/varint_field_sched_if.sv
// Descriptor intake and serializer-engine handshake bundle for varint_field_sched.
// The scheduler attaches through the master modport, its environment through slave.
interface varint_field_sched_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_value;
  logic [4:0]  in_field_type;
  logic [28:0] in_field_num;
  logic        eng_en;
  logic [63:0] eng_value;
  logic [4:0]  eng_field_type;
  logic [63:0] eng_dst_addr;
  logic        eng_done;
  logic [3:0]  eng_bytes_written;

  modport master (
    input  in_valid, in_value, in_field_type, in_field_num, eng_done, eng_bytes_written,
    output in_ready, eng_en, eng_value, eng_field_type, eng_dst_addr
  );

  modport slave (
    output in_valid, in_value, in_field_type, in_field_num, eng_done, eng_bytes_written,
    input  in_ready, eng_en, eng_value, eng_field_type, eng_dst_addr
  );
endinterface

// File: rtl/varint_field_sched.sv
// Sequences protobuf varint fields (value, then tag) through one shared serializer engine,
// moving the write cursor downward and totalling emitted bytes.
module varint_field_sched #(
  parameter int DEPTH = 4,
  parameter int GAP   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [63:0]          start_addr,
  varint_field_sched_if.master bus,
  output logic [63:0]          cursor,
  output logic [31:0]          total_bytes,
  output logic                 field_done,
  output logic                 busy,
  output logic                 err
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_VAL_RUN = 3'd1,
    ST_VAL_GAP = 3'd2,
    ST_TAG_RUN = 3'd3,
    ST_TAG_GAP = 3'd4
  } state_t;

  function automatic logic is_varint_type(input logic [4:0] t);
    case (t)
      5'd3, 5'd4, 5'd5, 5'd8, 5'd13, 5'd14, 5'd17, 5'd18: is_varint_type = 1'b1;
      default:                                            is_varint_type = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [3:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {29'd0, b};
    sat_add32 = sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

  logic [63:0]   fifo_value_r [DEPTH];
  logic [4:0]    fifo_type_r  [DEPTH];
  logic [28:0]   fifo_num_r   [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic [AW:0]   count_nxt_s;
  logic          in_ready_r;

  state_t        state_r;
  state_t        state_nxt_s;
  logic [GW-1:0] gap_cnt_r;
  logic [GW-1:0] gap_cnt_nxt_s;
  logic [28:0]   tag_num_r;
  logic [28:0]   tag_num_nxt_s;

  logic          eng_en_r,         eng_en_nxt_s;
  logic [63:0]   eng_value_r,      eng_value_nxt_s;
  logic [4:0]    eng_type_r,       eng_type_nxt_s;
  logic [63:0]   eng_dst_r,        eng_dst_nxt_s;
  logic [63:0]   cursor_r,         cursor_nxt_s;
  logic [31:0]   total_r,          total_nxt_s;
  logic          field_done_r,     field_done_nxt_s;
  logic          err_r,            err_nxt_s;
  logic          busy_r;

  logic          push_s;
  logic          pop_s;
  logic          head_ok_s;
  logic          gap_last_s;

  assign push_s     = bus.in_valid & in_ready_r;
  // Every descriptor reaching the head in IDLE is consumed, whether served or dropped.
  assign pop_s      = (state_r == ST_IDLE) & (count_r != {(AW+1){1'b0}});
  assign head_ok_s  = is_varint_type(fifo_type_r[rd_ptr_r]);
  assign gap_last_s = (gap_cnt_r == GW'(GAP - 1));

  // FIFO occupancy after this cycle's push/pop.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + (AW+1)'(1);
      2'b01:   count_nxt_s = count_r - (AW+1)'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Descriptor payload storage; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_value_r[wr_ptr_r] <= bus.in_value;
      fifo_type_r[wr_ptr_r]  <= bus.in_field_type;
      fifo_num_r[wr_ptr_r]   <= bus.in_field_num;
    end
  end

  // FIFO pointers, count and registered ready.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= {(AW+1){1'b0}};
      in_ready_r <= 1'b1;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      count_r    <= count_nxt_s;
      in_ready_r <= (count_nxt_s != (AW+1)'(DEPTH));
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) state_r <= ST_IDLE;
    else        state_r <= state_nxt_s;
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE:    if (pop_s && head_ok_s) state_nxt_s = ST_VAL_RUN; else state_nxt_s = ST_IDLE;
      ST_VAL_RUN: if (bus.eng_done)       state_nxt_s = ST_VAL_GAP; else state_nxt_s = ST_VAL_RUN;
      ST_VAL_GAP: if (gap_last_s)         state_nxt_s = ST_TAG_RUN; else state_nxt_s = ST_VAL_GAP;
      ST_TAG_RUN: if (bus.eng_done)       state_nxt_s = ST_TAG_GAP; else state_nxt_s = ST_TAG_RUN;
      ST_TAG_GAP: if (gap_last_s)         state_nxt_s = ST_IDLE;    else state_nxt_s = ST_TAG_GAP;
      default:                            state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM output/datapath next values; all outputs leave through registers.
  always_comb begin
    eng_en_nxt_s     = eng_en_r;
    eng_value_nxt_s  = eng_value_r;
    eng_type_nxt_s   = eng_type_r;
    eng_dst_nxt_s    = eng_dst_r;
    cursor_nxt_s     = cursor_r;
    total_nxt_s      = total_r;
    field_done_nxt_s = 1'b0;
    err_nxt_s        = err_r;
    gap_cnt_nxt_s    = gap_cnt_r;
    tag_num_nxt_s    = tag_num_r;
    case (state_r)
      ST_IDLE: begin
        gap_cnt_nxt_s = {GW{1'b0}};
        if (pop_s) begin
          if (head_ok_s) begin
            eng_en_nxt_s    = 1'b1;
            eng_value_nxt_s = fifo_value_r[rd_ptr_r];
            eng_type_nxt_s  = fifo_type_r[rd_ptr_r];
            eng_dst_nxt_s   = cursor_r;
            tag_num_nxt_s   = fifo_num_r[rd_ptr_r];
          end else begin
            err_nxt_s = 1'b1;
          end
        end else if (start && !busy_r) begin
          cursor_nxt_s = start_addr;
          total_nxt_s  = 32'd0;
        end else begin
          cursor_nxt_s = cursor_r;
        end
      end
      ST_VAL_RUN, ST_TAG_RUN: begin
        if (bus.eng_done) begin
          eng_en_nxt_s     = 1'b0;
          cursor_nxt_s     = cursor_r - {60'd0, bus.eng_bytes_written};
          total_nxt_s      = sat_add32(total_r, bus.eng_bytes_written);
          field_done_nxt_s = (state_r == ST_TAG_RUN);
          gap_cnt_nxt_s    = {GW{1'b0}};
        end else begin
          eng_en_nxt_s = 1'b1;
        end
      end
      ST_VAL_GAP: begin
        // Tag = (field_num << 3) | wire type 0, serialized as plain uint64.
        if (gap_last_s) begin
          eng_en_nxt_s    = 1'b1;
          eng_value_nxt_s = {32'd0, tag_num_r, 3'b000};
          eng_type_nxt_s  = 5'd4;
          eng_dst_nxt_s   = cursor_r;
          gap_cnt_nxt_s   = {GW{1'b0}};
        end else begin
          gap_cnt_nxt_s = gap_cnt_r + GW'(1);
        end
      end
      ST_TAG_GAP: begin
        if (gap_last_s) gap_cnt_nxt_s = {GW{1'b0}};
        else            gap_cnt_nxt_s = gap_cnt_r + GW'(1);
      end
      default: begin
        eng_en_nxt_s = 1'b0;
      end
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      eng_en_r     <= 1'b0;
      eng_value_r  <= 64'd0;
      eng_type_r   <= 5'd0;
      eng_dst_r    <= 64'd0;
      cursor_r     <= 64'd0;
      total_r      <= 32'd0;
      field_done_r <= 1'b0;
      err_r        <= 1'b0;
      gap_cnt_r    <= {GW{1'b0}};
      tag_num_r    <= 29'd0;
      busy_r       <= 1'b0;
    end else begin
      eng_en_r     <= eng_en_nxt_s;
      eng_value_r  <= eng_value_nxt_s;
      eng_type_r   <= eng_type_nxt_s;
      eng_dst_r    <= eng_dst_nxt_s;
      cursor_r     <= cursor_nxt_s;
      total_r      <= total_nxt_s;
      field_done_r <= field_done_nxt_s;
      err_r        <= err_nxt_s;
      gap_cnt_r    <= gap_cnt_nxt_s;
      tag_num_r    <= tag_num_nxt_s;
      busy_r       <= (state_nxt_s != ST_IDLE) | (count_nxt_s != {(AW+1){1'b0}});
    end
  end

  assign bus.in_ready       = in_ready_r;
  assign bus.eng_en         = eng_en_r;
  assign bus.eng_value      = eng_value_r;
  assign bus.eng_field_type = eng_type_r;
  assign bus.eng_dst_addr   = eng_dst_r;
  assign cursor             = cursor_r;
  assign total_bytes        = total_r;
  assign field_done         = field_done_r;
  assign busy               = busy_r;
  assign err                = err_r;

endmodule

// File: tb/tb_varint_field_sched.sv
// Self-checking bench for varint_field_sched: vector table, corner sequences and
// randomized descriptor streams against a field-level reference model and mock engine.
module tb_varint_field_sched;
  localparam int DEPTH = 4;
  localparam int GAP   = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [63:0] start_addr;
  logic [63:0] cursor;
  logic [31:0] total_bytes;
  logic        field_done;
  logic        busy;
  logic        err;

  varint_field_sched_if bus();

  varint_field_sched #(.DEPTH(DEPTH), .GAP(GAP)) dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr), .bus(bus),
    .cursor(cursor), .total_bytes(total_bytes), .field_done(field_done),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] saddr;
    logic [63:0] value;
    logic [4:0]  ftype;
    logic [28:0] fnum;
    bit          ok;
    logic [63:0] tag;
    logic [63:0] cur;
    logic [31:0] tot;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  int fd_cnt   = 0;
  bit mock_on  = 1'b1;
  int mock_override = -1;
  int mock_lat_lo = 1;
  int mock_lat_hi = 1;

  logic [63:0] op_val[$];
  logic [4:0]  op_type[$];
  logic [63:0] op_dst[$];
  logic [63:0] m_val[$];
  logic [4:0]  m_type[$];
  logic [28:0] m_num[$];

  function automatic int varint_len(input logic [63:0] v);
    int n;
    logic [63:0] x;
    n = 1;
    x = v;
    while (x >= 64'd128) begin
      x = x >> 7;
      n++;
    end
    return n;
  endfunction

  function automatic bit is_varint(input logic [4:0] t);
    return (t inside {5'd3, 5'd4, 5'd5, 5'd8, 5'd13, 5'd14, 5'd17, 5'd18});
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Mock serializer engine: records each operation, returns the varint length after a latency.
  initial begin : mock_engine
    int wait_cnt;
    int low_cnt;
    wait_cnt = -1;
    low_cnt  = 0;
    bus.eng_done = 1'b0;
    bus.eng_bytes_written = 4'd0;
    forever begin
      @(negedge clk);
      if (mock_on) begin
        bus.eng_done = 1'b0;
        bus.eng_bytes_written = 4'd0;
      end
      if (bus.eng_en !== 1'b1) begin
        wait_cnt = -1;
        low_cnt++;
      end else begin
        if (wait_cnt < 0) begin
          if (op_val.size() > 0) check("eng_en_gap", 64'(low_cnt >= GAP), 64'd1);
          op_val.push_back(bus.eng_value);
          op_type.push_back(bus.eng_field_type);
          op_dst.push_back(bus.eng_dst_addr);
          low_cnt  = 0;
          wait_cnt = int'($urandom_range(mock_lat_hi, mock_lat_lo));
        end else begin
          check("eng_value_stable", bus.eng_value, op_val[$]);
          check("eng_dst_stable", bus.eng_dst_addr, op_dst[$]);
        end
        if (wait_cnt > 0) begin
          wait_cnt--;
          if (wait_cnt == 0 && mock_on) begin
            bus.eng_done = 1'b1;
            bus.eng_bytes_written = (mock_override >= 0) ? 4'(mock_override)
                                                         : 4'(varint_len(bus.eng_value));
          end
        end
      end
    end
  end

  initial begin : fd_monitor
    forever begin
      @(negedge clk);
      if (field_done === 1'b1) fd_cnt++;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic do_reset();
    reset = 1'b0;
    start = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    op_val.delete(); op_type.delete(); op_dst.delete();
    m_val.delete(); m_type.delete(); m_num.delete();
    fd_cnt = 0;
  endtask

  // Called at a falling edge; returns at a falling edge after the descriptor was accepted.
  task automatic push_desc(input logic [63:0] v, input logic [4:0] t, input logic [28:0] n,
                           output bit stalled);
    int guard;
    guard = 0;
    stalled = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_value = v;
    bus.in_field_type = t;
    bus.in_field_num = n;
    while (bus.in_ready !== 1'b1 && guard < 500) begin
      stalled = 1'b1;
      @(negedge clk);
      guard++;
    end
    if (bus.in_ready !== 1'b1) begin
      check("push_timeout", 64'(bus.in_ready), 64'd1);
    end else begin
      m_val.push_back(v); m_type.push_back(t); m_num.push_back(n);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int g;
    g = 0;
    while (busy !== 1'b0 && g < budget) begin
      @(negedge clk);
      g++;
    end
    check("idle_timeout", 64'(busy), 64'd0);
  endtask

  task automatic pulse_start(input logic [63:0] addr);
    start = 1'b1;
    start_addr = addr;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Field-level reference: value op then tag op per varint descriptor, in FIFO order.
  task automatic check_model(input string tag, input logic [63:0] saddr);
    logic [63:0] cur;
    logic [63:0] tv;
    longint unsigned tot;
    bit e;
    int nfd;
    int nops;
    logic [63:0] ev[$];
    logic [4:0]  et[$];
    logic [63:0] ed[$];
    cur = saddr; tot = 0; e = 1'b0; nfd = 0;
    for (int i = 0; i < m_val.size(); i++) begin
      if (!is_varint(m_type[i])) begin
        e = 1'b1;
      end else begin
        ev.push_back(m_val[i]); et.push_back(m_type[i]); ed.push_back(cur);
        cur = cur - 64'(varint_len(m_val[i]));
        tot += longint'(varint_len(m_val[i]));
        tv = {32'd0, m_num[i], 3'b000};
        ev.push_back(tv); et.push_back(5'd4); ed.push_back(cur);
        cur = cur - 64'(varint_len(tv));
        tot += longint'(varint_len(tv));
        nfd++;
      end
    end
    if (tot > 64'hFFFF_FFFF) tot = 64'hFFFF_FFFF;
    check({tag, "_op_count"}, 64'(op_val.size()), 64'(ev.size()));
    nops = (op_val.size() < ev.size()) ? op_val.size() : ev.size();
    for (int k = 0; k < nops; k++) begin
      check($sformatf("%s_op%0d_value", tag, k), op_val[k], ev[k]);
      check($sformatf("%s_op%0d_type", tag, k), 64'(op_type[k]), 64'(et[k]));
      check($sformatf("%s_op%0d_dst", tag, k), op_dst[k], ed[k]);
    end
    check({tag, "_cursor"}, cursor, cur);
    check({tag, "_total"}, 64'(total_bytes), tot);
    check({tag, "_err"}, 64'(err), 64'(e));
    check({tag, "_field_done"}, 64'(fd_cnt), 64'(nfd));
  endtask

  initial begin : main
    vec_t vecs[11];
    bit stalled;
    int first_stall;
    int g;
    logic [63:0] saddr;
    logic [4:0] burst_types[6];

    vecs[0]  = '{64'h1000, 64'd150, 5'd4, 29'd1, 1'b1, 64'h08, 64'h0FFD, 32'd3};
    vecs[1]  = '{64'h1000, 64'd0, 5'd3, 29'd2, 1'b1, 64'h10, 64'h0FFE, 32'd2};
    vecs[2]  = '{64'h1000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd18, 29'd15, 1'b1, 64'h78, 64'h0FF5, 32'd11};
    vecs[3]  = '{64'h1000, 64'd300, 5'd13, 29'd16, 1'b1, 64'h80, 64'h0FFC, 32'd4};
    vecs[4]  = '{64'h1000, 64'd5, 5'd17, 29'h1FFF_FFFF, 1'b1, 64'hFFFF_FFF8, 64'h0FFA, 32'd6};
    vecs[5]  = '{64'h1000, 64'd7, 5'd1, 29'd3, 1'b0, 64'h0, 64'h1000, 32'd0};
    vecs[6]  = '{64'h1000, 64'd127, 5'd8, 29'd1, 1'b1, 64'h08, 64'h0FFE, 32'd2};
    vecs[7]  = '{64'h1000, 64'd128, 5'd14, 29'd2047, 1'b1, 64'h3FF8, 64'h0FFC, 32'd4};
    vecs[8]  = '{64'h1000, 64'd9, 5'd0, 29'd1, 1'b0, 64'h0, 64'h1000, 32'd0};
    vecs[9]  = '{64'h1000, 64'd1, 5'd5, 29'd1, 1'b1, 64'h08, 64'h0FFE, 32'd2};
    vecs[10] = '{64'h1, 64'd200, 5'd4, 29'd1, 1'b1, 64'h08, 64'hFFFF_FFFF_FFFF_FFFE, 32'd3};

    reset = 1'b0; start = 1'b0; start_addr = 64'd0;
    bus.in_valid = 1'b0; bus.in_value = 64'd0; bus.in_field_type = 5'd0; bus.in_field_num = 29'd0;
    @(negedge clk);
    do_reset();
    check("rst_eng_en", 64'(bus.eng_en), 64'd0);
    check("rst_cursor", cursor, 64'd0);
    check("rst_total", 64'(total_bytes), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_field_done", 64'(field_done), 64'd0);

    // Vector table: one field per row, start and push issued in the same cycle.
    for (int i = 0; i < 11; i++) begin
      do_reset();
      start = 1'b1;
      start_addr = vecs[i].saddr;
      push_desc(vecs[i].value, vecs[i].ftype, vecs[i].fnum, stalled);
      start = 1'b0;
      wait_idle(200);
      check($sformatf("row%0d_cursor", i), cursor, vecs[i].cur);
      check($sformatf("row%0d_total", i), 64'(total_bytes), 64'(vecs[i].tot));
      check($sformatf("row%0d_err", i), 64'(err), 64'(!vecs[i].ok));
      check($sformatf("row%0d_field_done", i), 64'(fd_cnt), vecs[i].ok ? 64'd1 : 64'd0);
      check($sformatf("row%0d_ops", i), 64'(op_val.size()), vecs[i].ok ? 64'd2 : 64'd0);
      if (vecs[i].ok && op_val.size() == 2) begin
        check($sformatf("row%0d_val_value", i), op_val[0], vecs[i].value);
        check($sformatf("row%0d_val_type", i), 64'(op_type[0]), 64'(vecs[i].ftype));
        check($sformatf("row%0d_val_dst", i), op_dst[0], vecs[i].saddr);
        check($sformatf("row%0d_tag_value", i), op_val[1], vecs[i].tag);
        check($sformatf("row%0d_tag_type", i), 64'(op_type[1]), 64'd4);
        check($sformatf("row%0d_tag_dst", i), op_dst[1],
              vecs[i].saddr - 64'(varint_len(vecs[i].value)));
      end
    end

    // Bad type followed by a good one: sticky err, only the second is serialized.
    do_reset();
    start = 1'b1; start_addr = 64'h8000;
    push_desc(64'd77, 5'd1, 29'd9, stalled);
    start = 1'b0;
    push_desc(64'd3, 5'd18, 29'd2, stalled);
    wait_idle(200);
    check_model("badtype", 64'h8000);
    check("badtype_tag", (op_val.size() == 2) ? op_val[1] : 64'd0, 64'h10);

    // Engine reporting zero bytes leaves cursor and total untouched.
    do_reset();
    mock_override = 0;
    start = 1'b1; start_addr = 64'h500;
    push_desc(64'd42, 5'd5, 29'd7, stalled);
    start = 1'b0;
    wait_idle(200);
    mock_override = -1;
    check("zero_cursor", cursor, 64'h500);
    check("zero_total", 64'(total_bytes), 64'd0);
    check("zero_tag_dst", (op_dst.size() == 2) ? op_dst[1] : 64'd0, 64'h500);
    check("zero_field_done", 64'(fd_cnt), 64'd1);

    // Burst of six with a slow engine: back-pressure after five accepted.
    do_reset();
    mock_lat_lo = 3; mock_lat_hi = 3;
    burst_types = '{5'd4, 5'd5, 5'd13, 5'd17, 5'd18, 5'd8};
    first_stall = -1;
    start = 1'b1; start_addr = 64'h4000;
    for (int i = 0; i < 6; i++) begin
      push_desc(64'(i * 1000 + 1), burst_types[i], 29'(i + 1), stalled);
      start = 1'b0;
      if (stalled && first_stall < 0) first_stall = i;
    end
    wait_idle(1000);
    check("burst_first_stall", 64'(first_stall), 64'd5);
    check_model("burst", 64'h4000);

    // Reset in the middle of a value operation, then a stray eng_done.
    do_reset();
    mock_on = 1'b0;
    start = 1'b1; start_addr = 64'h3000;
    push_desc(64'd1234, 5'd4, 29'd3, stalled);
    start = 1'b0;
    g = 0;
    while (bus.eng_en !== 1'b1 && g < 20) begin
      @(negedge clk);
      g++;
    end
    check("midrst_op_started", 64'(bus.eng_en), 64'd1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("midrst_eng_en", 64'(bus.eng_en), 64'd0);
    check("midrst_cursor", cursor, 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    bus.eng_done = 1'b1; bus.eng_bytes_written = 4'd5;
    @(negedge clk);
    bus.eng_done = 1'b0; bus.eng_bytes_written = 4'd0;
    @(negedge clk);
    check("late_done_cursor", cursor, 64'd0);
    check("late_done_total", 64'(total_bytes), 64'd0);
    check("late_done_eng_en", 64'(bus.eng_en), 64'd0);
    check("late_done_busy", 64'(busy), 64'd0);
    check("late_done_field_done", 64'(fd_cnt), 64'd0);
    mock_on = 1'b1;

    // start during the tag operation is ignored; after idle it reloads.
    do_reset();
    mock_lat_lo = 2; mock_lat_hi = 2;
    start = 1'b1; start_addr = 64'h1000;
    push_desc(64'd150, 5'd4, 29'd1, stalled);
    start = 1'b0;
    g = 0;
    while (op_val.size() < 2 && g < 50) begin
      @(negedge clk);
      g++;
    end
    check("busystart_in_tag", 64'(bus.eng_en), 64'd1);
    pulse_start(64'h2000);
    wait_idle(200);
    check("busystart_cursor", cursor, 64'h0FFD);
    check("busystart_total", 64'(total_bytes), 64'd3);
    pulse_start(64'h2000);
    check("idlestart_cursor", cursor, 64'h2000);
    check("idlestart_total", 64'(total_bytes), 64'd0);

    // Randomized descriptor streams against the field-level model.
    mock_lat_lo = 1; mock_lat_hi = 4;
    for (int r = 0; r < 4; r++) begin
      do_reset();
      saddr = {32'($urandom), 32'($urandom)};
      start = 1'b1; start_addr = saddr;
      for (int i = 0; i < 8; i++) begin
        push_desc({32'($urandom), 32'($urandom)} >> $urandom_range(63, 0),
                  5'($urandom_range(19, 0)), 29'($urandom), stalled);
        start = 1'b0;
        repeat ($urandom_range(3, 0)) @(negedge clk);
      end
      wait_idle(2000);
      check_model($sformatf("rand%0d", r), saddr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/varint_field_sched.md
Name: varint_field_sched

Overview:
- Scheduler that sequences protobuf varint fields through one shared varint-serializer engine.
- Takes field descriptors (value, field_type, field_number) into a small FIFO.
- For each field it runs two engine operations, value first and then the tag. It keeps the write cursor moving downward (back-to-front serialization) and totals the bytes emitted.
- Sits between the message walker and the varint serializer/DRAM write path.

Parameters:
- DEPTH, 4, descriptor FIFO entries (power of two, at least 2).
- GAP, 1, idle cycles with eng_en low between engine operations (at least 1).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset (asserted when 0).
- start  in  1  one-cycle pulse that loads start_addr into the cursor and clears total_bytes. Honoured only when busy=0.
- start_addr  in  64  first (highest) destination byte address.
- in_valid  in  1  descriptor valid.
- in_ready  out  1  FIFO not full.
- in_value  in  64  field value.
- in_field_type  in  5  protobuf field type code.
- in_field_num  in  29  protobuf field number.
- eng_en  out  1  engine enable, held high for a whole operation.
- eng_value  out  64  value presented to the engine.
- eng_field_type  out  5  type presented to the engine.
- eng_dst_addr  out  64  engine destination address, equal to the cursor.
- eng_done  in  1  engine completion pulse.
- eng_bytes_written  in  4  bytes written by the engine, valid while eng_done=1.
- cursor  out  64  next free (highest unwritten) address.
- total_bytes  out  32  bytes emitted since the last start.
- field_done  out  1  one-cycle pulse after a field's tag completes.
- busy  out  1  state != IDLE or FIFO non-empty.
- err  out  1  sticky: a descriptor with a non-varint type was dropped.

Behaviour:
- Reset (reset=0 at a clk edge) sets all of the following to 0 on the next cycle: FIFO pointers and count, state=IDLE, eng_en, eng_value, eng_field_type, eng_dst_addr, cursor, total_bytes, field_done, err. in_ready=1 after reset. Reset during an active operation drops eng_en on the next cycle with no completion; the partial field is lost.
- FIFO:
  - Push when in_valid & in_ready.
  - Pop on the IDLE->VAL_RUN transition.
  - Push and pop in the same cycle are both allowed; count is unchanged.
  - in_ready = (count != DEPTH). A push attempted while full is ignored.
- Varint types are 3,4,5,8,13,14,17,18.
- States:
  - IDLE:
    - If the FIFO is non-empty and the head type is not a varint type: pop it, set err=1, stay in IDLE.
    - If the FIFO is non-empty and the head type is a varint type: pop it and go to VAL_RUN, with eng_value=value, eng_field_type=type, eng_dst_addr=cursor, eng_en=1 from the next cycle.
  - VAL_RUN:
    - eng_en=1, outputs held stable.
    - On eng_done: cursor -= eng_bytes_written, total_bytes += eng_bytes_written, eng_en=0, go to VAL_GAP.
  - VAL_GAP:
    - Wait GAP cycles with eng_en=0.
    - Load eng_value = (field_num << 3) | 0 (zero-extended to 64 bits), eng_field_type=4 (uint64, no zigzag), eng_dst_addr=cursor (already updated).
    - Go to TAG_RUN.
  - TAG_RUN:
    - Same completion rule as VAL_RUN.
    - On eng_done go to TAG_GAP and pulse field_done in the following cycle.
  - TAG_GAP: wait GAP cycles, then go to IDLE.
- Latency, empty FIFO to field_done, is 1 (pop) + engine latency + GAP + engine latency + 1.
- eng_done outside VAL_RUN/TAG_RUN is ignored.
- eng_bytes_written=0 on done is legal: cursor and total are unchanged.
- Cursor arithmetic is modulo 2^64; below-zero wraps with no flag. total_bytes saturates at 0xFFFFFFFF.
- start while busy=1 is ignored. start while busy=0 and in_valid on the same cycle are both accepted; the descriptor uses the new cursor.
- Descriptors are served strictly in FIFO order; one field at a time.

Test Plan:
- Single field: start with start_addr=0x1000; push value=150, type=4, num=1. Expected:
  - Value op shows eng_dst_addr=0x1000, eng_value=150.
  - The mock returns 2, making cursor 0x0FFE.
  - Tag op shows eng_value=0x08, eng_field_type=4, eng_dst_addr=0x0FFE.
  - The mock returns 1. Final cursor=0x0FFD, total_bytes=3, exactly one field_done pulse.
- Burst/backpressure with DEPTH=4: push 6 descriptors back-to-back.
  - in_ready drops after 4 (5 if the first pop has happened).
  - All 6 fields complete in order and field_done pulses 6 times.
  - eng_en goes low for at least GAP cycles between every operation.
- Bad type: push type=1 (double) then type=18 num=2.
  - err=1, no engine operation for the first descriptor.
  - The second serializes with a tag value of 0x10.
- Large field number: num=0x1FFFFFFF gives a tag eng_value of 0xFFFFFFF8.
- Reset mid-op: drive reset=0 during VAL_RUN.
  - Next cycle: eng_en=0, cursor=0, FIFO empty, busy=0.
  - A late eng_done is ignored.
- start while busy: pulse start with 0x2000 during TAG_RUN.
  - Cursor continues from the prior value.
  - A start after busy=0 loads 0x2000 and clears total_bytes.
